// File: rtl/spi_tx_sched_if.sv
// Byte-stream requester channel: valid/ready handshake carrying one byte and an end-of-packet flag.
interface spi_tx_sched_if;
    logic       valid;
    logic [7:0] data;
    logic       last;
    logic       ready;

    modport master (output valid, data, last, input ready);
    modport slave  (input valid, data, last, output ready);
endinterface

// File: rtl/spi_tx_sched.sv
// Round-robin scheduler sharing one SPI byte transmitter between two packet requesters.
// Holds chip select for a whole packet, enforces an inter-packet gap, aborts on underrun or timeout.
module spi_tx_sched #(
    parameter int CS_GAP  = 16,
    parameter int TIMEOUT = 512
) (
    input  logic          clk,
    input  logic          reset_n,
    spi_tx_sched_if.slave rq0,
    spi_tx_sched_if.slave rq1,
    output logic          spi_onoff,
    output logic [7:0]    spi_data,
    input  logic          spi_valid,
    output logic [1:0]    grant,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0] G_LAST = GW'(CS_GAP - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;

    state_t        state;
    state_t        next_state;
    logic [TW-1:0] t_cnt;
    logic [GW-1:0] g_cnt;
    logic          last_r;
    logic          last_owner;   // 1: requester 1 owned the previous packet
    logic          pick1;
    logic          sel_valid;
    logic [7:0]    sel_data;
    logic          sel_last;
    logic          accept;
    logic          t_expired;
    logic          g_expired;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        // NOTE: default assignment first, so no path through the case leaves next_state unassigned (latch).
        next_state = state;
        case (state)
            IDLE: if (rq0.valid || rq1.valid) next_state = LOAD;
            LOAD: next_state = SEND;
            SEND: begin
                if (spi_valid) begin
                    if (last_r || !sel_valid) next_state = GAP;
                end else if (t_expired) begin
                    next_state = GAP;
                end
            end
            GAP:  if (g_expired) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Owner mux follows the registered grant; ready is the only combinational output.
    always_comb begin
        sel_valid = grant[1] ? rq1.valid : rq0.valid;
        sel_data  = grant[1] ? rq1.data  : rq0.data;
        sel_last  = grant[1] ? rq1.last  : rq0.last;
        pick1     = rq1.valid && (!rq0.valid || !last_owner);
        t_expired = (t_cnt == T_LAST);
        g_expired = (g_cnt == G_LAST);
        accept    = (state == LOAD) || ((state == SEND) && spi_valid && !last_r);
        rq0.ready = accept && grant[0];
        rq1.ready = accept && grant[1];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            spi_onoff  <= 1'b0;
            spi_data   <= 8'h00;
            grant      <= 2'b00;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            last_owner <= 1'b1;
            last_r     <= 1'b0;
            t_cnt      <= '0;
            g_cnt      <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            busy <= (next_state != IDLE);
            case (state)
                IDLE: begin
                    if (rq0.valid || rq1.valid) begin
                        grant      <= pick1 ? 2'b10 : 2'b01;
                        last_owner <= pick1;
                    end
                end
                LOAD: begin
                    spi_data  <= sel_data;
                    last_r    <= sel_last;
                    spi_onoff <= 1'b1;
                    t_cnt     <= '0;
                end
                SEND: begin
                    if (spi_valid) begin
                        t_cnt <= '0;
                        if (last_r) begin
                            spi_onoff <= 1'b0;
                            grant     <= 2'b00;
                            done      <= 1'b1;
                        end else if (sel_valid) begin
                            spi_data <= sel_data;
                            last_r   <= sel_last;
                        end else begin
                            spi_onoff <= 1'b0;
                            grant     <= 2'b00;
                            err       <= 1'b1;
                        end
                    end else if (t_expired) begin
                        t_cnt     <= '0;
                        spi_onoff <= 1'b0;
                        grant     <= 2'b00;
                        err       <= 1'b1;
                    end else begin
                        t_cnt <= t_cnt + TW'(1);
                    end
                end
                GAP: g_cnt <= g_expired ? '0 : g_cnt + GW'(1);
                default: ;
            endcase
        end
    end

endmodule
